// File: rtl/calculation_unit_exponent_arbiter_pkg.sv
// Shared FPU constants and types for the exponent arbiter and its adder.
// The requester count, tag width and exponent widths are fixed here for every user.
package calculation_unit_exponent_arbiter_pkg;

    localparam int NUM_REQ   = 2;
    localparam int TAG_W     = 3;
    localparam int EXP_IN_W  = 8;
    localparam int EXP_OUT_W = 10;

    typedef logic [EXP_IN_W-1:0]  exp_in_t;
    typedef logic [EXP_OUT_W-1:0] exp_out_t;
    typedef logic [TAG_W-1:0]     tag_t;

    // Requester 0 is the multiply path, requester 1 the divide path.
    typedef enum logic {
        REQ_MUL = 1'b0,
        REQ_DIV = 1'b1
    } req_id_t;

    function automatic exp_out_t sign_extend(input exp_in_t v);
        return {{(EXP_OUT_W-EXP_IN_W){v[EXP_IN_W-1]}}, v};
    endfunction

endpackage

// File: rtl/calculation_unit_exponent_adder.sv
// Combinational exponent adder: sign-extends both operands and adds modulo 2^10.
// There is no saturation; overflow simply wraps.
module calculation_unit_exponent_adder
    import calculation_unit_exponent_arbiter_pkg::*;
(
    input  logic [EXP_IN_W-1:0]  exponent_a,
    input  logic [EXP_IN_W-1:0]  exponent_b,
    output logic [EXP_OUT_W-1:0] sum
);

    assign sum = sign_extend(exponent_a) + sign_extend(exponent_b);

endmodule

// File: rtl/calculation_unit_exponent_arbiter.sv
// Round-robin arbiter sharing one exponent adder between the multiply and divide paths.
// A single output register gives one-cycle latency and full throughput under a ready/valid handshake.
module calculation_unit_exponent_arbiter
    import calculation_unit_exponent_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*EXP_IN_W-1:0] req_exponent_a,
    input  logic [NUM_REQ*EXP_IN_W-1:0] req_exponent_b,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [EXP_OUT_W-1:0]        result_exponent,
    output logic                        result_source,
    output logic [TAG_W-1:0]            result_tag
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; ready never waits on valid's data and valid may drop at any time.
    logic                 out_free;
    logic                 grant_sel;
    logic                 accept;
    logic                 last_grant;
    logic [EXP_IN_W-1:0]  op_a;
    logic [EXP_IN_W-1:0]  op_b;
    logic [TAG_W-1:0]     op_tag;
    logic [EXP_OUT_W-1:0] sum;

    always_comb begin
        out_free  = !result_valid || result_ready;
        grant_sel = 1'b0;
        req_ready = '0;
        if (req_valid == 2'b11) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = ~req_valid[0];
        end
        // Ready is held low during reset even though the output stage reads as free.
        if (!reset && out_free && (req_valid != '0)) begin
            req_ready[grant_sel] = 1'b1;
        end
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        op_a   = grant_sel ? req_exponent_a[2*EXP_IN_W-1:EXP_IN_W] : req_exponent_a[EXP_IN_W-1:0];
        op_b   = grant_sel ? req_exponent_b[2*EXP_IN_W-1:EXP_IN_W] : req_exponent_b[EXP_IN_W-1:0];
        op_tag = grant_sel ? req_tag[2*TAG_W-1:TAG_W]              : req_tag[TAG_W-1:0];
    end

    calculation_unit_exponent_adder u_adder (
        .exponent_a (op_a),
        .exponent_b (op_b),
        .sum        (sum)
    );

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid    <= 1'b0;
            result_exponent <= '0;
            result_source   <= 1'b0;
            result_tag      <= '0;
            last_grant      <= 1'b1;
        end else if (accept) begin
            result_valid    <= 1'b1;
            result_exponent <= sum;
            result_source   <= grant_sel;
            result_tag      <= op_tag;
            last_grant      <= grant_sel;
        end else if (result_ready) begin
            result_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/calculation_unit_exponent_arbiter.md
CALCULATION_UNIT_EXPONENT_ARBITER -- requirements
Module: calculation_unit_exponent_arbiter

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 req_valid  input  [1:0]  per-requester operand valid (0 = multiply path, 1 = divide path).
REQ-005 req_ready  output  [1:0]  per-requester accept; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-006 req_exponent_a  input  2x[7:0]  per-requester first exponent operand (two's-complement aligned exponent).
REQ-007 req_exponent_b  input  2x[7:0]  per-requester second exponent operand.
REQ-008 req_tag  input  2x[2:0]  per-requester opaque tag, returned with the result.
REQ-009 result_valid  output  1  result register holds a valid sum.
REQ-010 result_ready  input  1  downstream accept; result is consumed when result_valid and result_ready are both high.
REQ-011 result_exponent  output  [9:0]  registered sum.
REQ-012 result_source  output  1  index of the requester that produced the result.
REQ-013 result_tag  output  [2:0]  tag captured with the operands.

Function
REQ-014 The block SHALL share a single combinational 10-bit exponent adder between the two requesters.
REQ-015 The sum SHALL be each 8-bit operand sign-extended by 2 bits, then added modulo 2^10, with no saturation.
REQ-016 The output stage SHALL be "free" when result_valid is 0, or when result_valid and result_ready are both 1 in the same cycle.
REQ-017 When the output stage is not free, req_ready SHALL be 2'b00.
REQ-018 When the output stage is free, at most one req_ready bit SHALL be high, and it SHALL go to the requester selected by the grant rule.
REQ-019 Grant rule, round-robin:
- A sole valid requester is granted.
- When both are valid, the requester not granted last SHALL be granted.
- last_grant SHALL update only on an accepted transfer.
REQ-020 req_ready SHALL depend combinationally on req_valid, result_valid, result_ready and last_grant only; it SHALL NOT depend on operand data.
REQ-021 Latency SHALL be 1 cycle. Operands accepted at edge N produce result_valid = 1 with the sum, source and tag after edge N.
REQ-022 Output registers SHALL hold their values while result_valid = 1 and result_ready = 0.
REQ-023 On the same cycle as a consume with no new accept, result_valid SHALL clear to 0 at the next edge.
REQ-024 On the same cycle as a consume with a new accept, the output registers SHALL load the new result; result_valid stays 1 (full throughput, one result per cycle).
REQ-025 req_valid SHALL NOT be required to stay asserted without ready; a requester may withdraw at any time without effect.
REQ-026 No combinational path SHALL exist from req_valid to result_valid; result_ready to req_ready is permitted.

Reset
REQ-027 Reset SHALL force:
- result_valid = 0, result_exponent = 10'd0, result_source = 0, result_tag = 3'd0.
- last_grant = 1, so requester 0 wins the first contention.
REQ-028 While reset is high, req_ready SHALL be 2'b00.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight result; no result emerges after reset release until a new accept.

Structure
REQ-030 Requester count (2), tag width (3) and exponent widths (8 in, 10 out) SHALL be constants in the shared FPU package.
REQ-031 The adder SHALL be one instance of the existing calculation_unit_exponent_adder sub-module, fed by a 2:1 operand mux.
REQ-032 Arbitration and the output register SHALL live in this module; no further sub-modules.

Verification
REQ-033 Single request, downstream always ready:
- Stimulus: req 0 with a = 8'h7F, b = 8'h01, tag = 5.
- Required: one cycle later result_exponent = 10'h080, source = 0, tag = 5.
REQ-034 Sign extension:
- Stimulus: req 1 with a = 8'h80, b = 8'hFF.
- Required: result_exponent = 10'h37F, i.e. -129.
REQ-035 Contention after reset:
- Stimulus: both valid continuously for 4 cycles.
- Required: grants 0, 1, 0, 1; results stream back-to-back with result_valid constantly 1.
REQ-036 Backpressure:
- Stimulus: result_ready = 0 for 3 cycles while both request.
- Required: req_ready = 00 and outputs stable; on release, one result is consumed and the next grant loads in the same cycle.
REQ-037 Reset mid-flight:
- Stimulus: assert reset while result_valid = 1.
- Required: result_valid = 0 immediately (asynchronous); after release, first contention is granted to requester 0.
REQ-038 Wrap-around:
- Stimulus: a = b = 8'h7F.
- Required: 10'h0FE.
- Stimulus: a = b = 8'h80.
- Required: 10'h300.
